multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/writeback
// over one shared memory port and one ALU, and drives every datapath select and enable.
module multicycle_controller #(
    parameter int OP_W    = 7,
    parameter int STATE_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            Zero,
    input  logic            MemReady,
    output logic [1:0]      ImmSrc,
    output logic            PCWrite,
    output logic            AdrSrc,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ALUControl,
    output logic            RegWrite,
    output logic            Illegal
);

    localparam logic [OP_W-1:0] OP_LW  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_LUI = OP_W'(7'b0110111);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BEQ      = STATE_W'(9),
        LUI      = STATE_W'(10),
        ILLEGAL  = STATE_W'(11)
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic [1:0]  w_aluOp;
    logic        w_pcWrite;
    logic        w_memWrite;
    logic        w_irWrite;
    logic        w_regWrite;
    logic        w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:    r_state <= MemReady ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= MEMADR;
                        OP_R:         r_state <= EXECUTER;
                        OP_I:         r_state <= EXECUTEI;
                        OP_BEQ:       r_state <= (funct3 == 3'b000) ? BEQ : ILLEGAL;
                        OP_LUI:       r_state <= LUI;
                        default:      r_state <= ILLEGAL;
                    endcase
                end
                MEMADR:   r_state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  r_state <= MemReady ? MEMWB : MEMREAD;
                MEMWRITE: r_state <= MemReady ? FETCH : MEMWRITE;
                EXECUTER: r_state <= ALUWB;
                EXECUTEI: r_state <= ALUWB;
                default:  r_state <= FETCH;
            endcase
        end
    end

    // During reset the selects show FETCH values while every enable is held low.
    always_comb begin
        w_state    = rst ? FETCH : r_state;
        w_aluOp    = 2'b00;
        w_pcWrite  = 1'b0;
        w_memWrite = 1'b0;
        w_irWrite  = 1'b0;
        w_regWrite = 1'b0;
        w_illegal  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        case (w_state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irWrite = MemReady;
                w_pcWrite = MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                w_regWrite = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                w_aluOp = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_aluOp = 2'b10;
            end
            ALUWB: begin
                w_regWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA   = 2'b10;
                w_aluOp   = 2'b01;
                w_pcWrite = Zero;
            end
            LUI: begin
                ResultSrc  = 2'b11;
                w_regWrite = 1'b1;
            end
            ILLEGAL: begin
                w_illegal = 1'b1;
            end
            default: begin
                ResultSrc = 2'b00;
            end
        endcase
        PCWrite  = w_pcWrite & ~rst;
        MemWrite = w_memWrite & ~rst;
        IRWrite  = w_irWrite & ~rst;
        RegWrite = w_regWrite & ~rst;
        Illegal  = w_illegal & ~rst;
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_LUI:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Subtract for R-type sub only; addi with Instr[30] set is still an add.
    always_comb begin
        ALUControl = 3'b000;
        case (w_aluOp)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table of inputs and
// hand-derived outputs, plus hand-written stall, ALU-decode and reset sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic [1:0] ImmSrc;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       Illegal;

    int total = 0;
    int bad = 0;

    multicycle_controller #(.OP_W(7), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .ImmSrc(ImmSrc), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // Packed as {ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, RegWrite, Illegal}.
    logic [16:0] actual;
    assign actual = {ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ALUControl, RegWrite, Illegal};

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [1:0] IM_I = 2'b00;
    localparam logic [1:0] IM_S = 2'b01;
    localparam logic [1:0] IM_B = 2'b10;
    localparam logic [1:0] IM_U = 2'b11;

    // Body fields: pc adr mw ir _ res _ srcA _ srcB _ alu _ rw il
    localparam logic [14:0] E_FWAIT = 15'b0000_10_00_10_000_00;
    localparam logic [14:0] E_FGO   = 15'b1001_10_00_10_000_00;
    localparam logic [14:0] E_DEC   = 15'b0000_00_01_01_000_00;
    localparam logic [14:0] E_MADR  = 15'b0000_00_10_01_000_00;
    localparam logic [14:0] E_MRD   = 15'b0100_00_00_00_000_00;
    localparam logic [14:0] E_MWB   = 15'b0000_01_00_00_000_10;
    localparam logic [14:0] E_MWR   = 15'b0110_00_00_00_000_00;
    localparam logic [14:0] E_EXSUB = 15'b0000_00_10_00_001_00;
    localparam logic [14:0] E_EXADI = 15'b0000_00_10_01_000_00;
    localparam logic [14:0] E_AWB   = 15'b0000_00_00_00_000_10;
    localparam logic [14:0] E_BEQT  = 15'b1000_00_10_00_001_00;
    localparam logic [14:0] E_BEQN  = 15'b0000_00_10_00_001_00;
    localparam logic [14:0] E_LUI   = 15'b0000_11_00_00_000_10;
    localparam logic [14:0] E_ILL   = 15'b0000_00_00_00_000_01;

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        logic        ready;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input string name, input logic r, input logic [6:0] o,
                                   input logic [2:0] f3, input logic f7, input logic z,
                                   input logic rdy, input logic [1:0] imm, input logic [14:0] body);
        vec_t v;
        v.name  = name;
        v.rst   = r;
        v.op    = o;
        v.f3    = f3;
        v.f7    = f7;
        v.zero  = z;
        v.ready = rdy;
        v.exp   = {imm, body};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        op       = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        Zero     = v.zero;
        MemReady = v.ready;
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        total++;
        if (actual !== v.exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b", v.name, actual, v.exp);
        end
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

    task automatic runAluR(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [1:0] srcB, input logic [2:0] alu);
        step(mkVec({name, "_fetch"}, 1'b0, o, f3, f7, 1'b0, 1'b1, IM_I, E_FGO));
        step(mkVec({name, "_decode"}, 1'b0, o, f3, f7, 1'b0, 1'b1, IM_I, E_DEC));
        step(mkVec({name, "_exec"}, 1'b0, o, f3, f7, 1'b0, 1'b1, IM_I,
                   {4'b0000, 2'b00, 2'b10, srcB, alu, 2'b00}));
        step(mkVec({name, "_wb"}, 1'b0, o, f3, f7, 1'b0, 1'b1, IM_I, E_AWB));
    endtask

    initial begin
        vecs.push_back(mkVec("rst_c1",     1, OPC_R,   3'b000, 1, 0, 1, IM_I, E_FWAIT));
        vecs.push_back(mkVec("rst_c2",     1, OPC_R,   3'b000, 1, 0, 1, IM_I, E_FWAIT));
        vecs.push_back(mkVec("r_fetch",    0, OPC_R,   3'b000, 1, 0, 1, IM_I, E_FGO));
        vecs.push_back(mkVec("r_decode",   0, OPC_R,   3'b000, 1, 0, 1, IM_I, E_DEC));
        vecs.push_back(mkVec("r_exec_sub", 0, OPC_R,   3'b000, 1, 0, 1, IM_I, E_EXSUB));
        vecs.push_back(mkVec("r_aluwb",    0, OPC_R,   3'b000, 1, 0, 1, IM_I, E_AWB));
        vecs.push_back(mkVec("lw_fetch",   0, OPC_LW,  3'b010, 0, 0, 1, IM_I, E_FGO));
        vecs.push_back(mkVec("lw_decode",  0, OPC_LW,  3'b010, 0, 0, 0, IM_I, E_DEC));
        vecs.push_back(mkVec("lw_memadr",  0, OPC_LW,  3'b010, 0, 0, 0, IM_I, E_MADR));
        vecs.push_back(mkVec("lw_rd_w1",   0, OPC_LW,  3'b010, 0, 0, 0, IM_I, E_MRD));
        vecs.push_back(mkVec("lw_rd_w2",   0, OPC_LW,  3'b010, 0, 0, 0, IM_I, E_MRD));
        vecs.push_back(mkVec("lw_rd_w3",   0, OPC_LW,  3'b010, 0, 0, 0, IM_I, E_MRD));
        vecs.push_back(mkVec("lw_rd_go",   0, OPC_LW,  3'b010, 0, 0, 1, IM_I, E_MRD));
        vecs.push_back(mkVec("lw_memwb",   0, OPC_LW,  3'b010, 0, 0, 1, IM_I, E_MWB));
        vecs.push_back(mkVec("sw_fetch",   0, OPC_SW,  3'b010, 0, 0, 1, IM_S, E_FGO));
        vecs.push_back(mkVec("sw_decode",  0, OPC_SW,  3'b010, 0, 0, 1, IM_S, E_DEC));
        vecs.push_back(mkVec("sw_memadr",  0, OPC_SW,  3'b010, 0, 0, 1, IM_S, E_MADR));
        vecs.push_back(mkVec("sw_wr_w1",   0, OPC_SW,  3'b010, 0, 0, 0, IM_S, E_MWR));
        vecs.push_back(mkVec("sw_wr_w2",   0, OPC_SW,  3'b010, 0, 0, 0, IM_S, E_MWR));
        vecs.push_back(mkVec("sw_wr_go",   0, OPC_SW,  3'b010, 0, 0, 1, IM_S, E_MWR));
        vecs.push_back(mkVec("beqt_fetch", 0, OPC_BEQ, 3'b000, 0, 0, 1, IM_B, E_FGO));
        vecs.push_back(mkVec("beqt_dec",   0, OPC_BEQ, 3'b000, 0, 0, 1, IM_B, E_DEC));
        vecs.push_back(mkVec("beqt_beq",   0, OPC_BEQ, 3'b000, 0, 1, 1, IM_B, E_BEQT));
        vecs.push_back(mkVec("beqn_fetch", 0, OPC_BEQ, 3'b000, 0, 0, 1, IM_B, E_FGO));
        vecs.push_back(mkVec("beqn_dec",   0, OPC_BEQ, 3'b000, 0, 0, 1, IM_B, E_DEC));
        vecs.push_back(mkVec("beqn_beq",   0, OPC_BEQ, 3'b000, 0, 0, 1, IM_B, E_BEQN));
        vecs.push_back(mkVec("lui_fetch",  0, OPC_LUI, 3'b000, 0, 0, 1, IM_U, E_FGO));
        vecs.push_back(mkVec("lui_dec",    0, OPC_LUI, 3'b000, 0, 0, 1, IM_U, E_DEC));
        vecs.push_back(mkVec("lui_wb",     0, OPC_LUI, 3'b000, 0, 0, 1, IM_U, E_LUI));
        vecs.push_back(mkVec("addi_fetch", 0, OPC_I,   3'b000, 1, 0, 1, IM_I, E_FGO));
        vecs.push_back(mkVec("addi_dec",   0, OPC_I,   3'b000, 1, 0, 1, IM_I, E_DEC));
        vecs.push_back(mkVec("addi_exec",  0, OPC_I,   3'b000, 1, 0, 1, IM_I, E_EXADI));
        vecs.push_back(mkVec("addi_wb",    0, OPC_I,   3'b000, 1, 0, 1, IM_I, E_AWB));
        vecs.push_back(mkVec("jal_fetch",  0, OPC_JAL, 3'b000, 0, 0, 1, IM_I, E_FGO));
        vecs.push_back(mkVec("jal_dec",    0, OPC_JAL, 3'b000, 0, 0, 1, IM_I, E_DEC));
        vecs.push_back(mkVec("jal_illegal",0, OPC_JAL, 3'b000, 0, 0, 1, IM_I, E_ILL));
        vecs.push_back(mkVec("jal_refetch",0, OPC_JAL, 3'b000, 0, 0, 0, IM_I, E_FWAIT));

        foreach (vecs[i]) step(vecs[i]);

        // Memory never answering: fetch must sit still with no enables.
        for (int i = 0; i < 20; i++)
            step(mkVec("fetch_stall", 0, OPC_SW, 3'b000, 0, 0, 0, IM_S, E_FWAIT));

        runAluR("r_add", OPC_R, 3'b000, 1'b0, 2'b00, 3'b000);
        runAluR("r_slt", OPC_R, 3'b010, 1'b0, 2'b00, 3'b101);
        runAluR("r_or",  OPC_R, 3'b110, 1'b0, 2'b00, 3'b011);
        runAluR("r_and", OPC_R, 3'b111, 1'b1, 2'b00, 3'b010);
        runAluR("r_sll", OPC_R, 3'b001, 1'b0, 2'b00, 3'b000);
        runAluR("i_ori", OPC_I, 3'b110, 1'b0, 2'b01, 3'b011);

        step(mkVec("bne_fetch",   0, OPC_BEQ, 3'b001, 0, 1, 1, IM_B, E_FGO));
        step(mkVec("bne_dec",     0, OPC_BEQ, 3'b001, 0, 1, 1, IM_B, E_DEC));
        step(mkVec("bne_illegal", 0, OPC_BEQ, 3'b001, 0, 1, 1, IM_B, E_ILL));

        // Reset landing in the middle of a store that memory has not yet accepted.
        step(mkVec("rsw_fetch",   0, OPC_SW, 3'b010, 0, 0, 1, IM_S, E_FGO));
        step(mkVec("rsw_decode",  0, OPC_SW, 3'b010, 0, 0, 1, IM_S, E_DEC));
        step(mkVec("rsw_memadr",  0, OPC_SW, 3'b010, 0, 0, 1, IM_S, E_MADR));
        step(mkVec("rsw_memwr",   0, OPC_SW, 3'b010, 0, 0, 0, IM_S, E_MWR));
        step(mkVec("rsw_rst",     1, OPC_SW, 3'b010, 0, 0, 0, IM_S, E_FWAIT));
        step(mkVec("rsw_after1",  0, OPC_SW, 3'b010, 0, 0, 0, IM_S, E_FWAIT));
        step(mkVec("rsw_after2",  0, OPC_SW, 3'b010, 0, 0, 1, IM_S, E_FGO));
        step(mkVec("rsw_decode2", 0, OPC_SW, 3'b010, 0, 0, 1, IM_S, E_DEC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
